// File: rtl/icblbc_greedy_code_sequencer_if.sv
// Bus bundle for the greedy code sequencer: scan control, result flags and code read port.
interface icblbc_greedy_code_sequencer_if #(
    parameter int unsigned MAX_N = 8
);
    logic             start;
    logic [3:0]       n;
    logic [3:0]       min_hd;
    logic [MAX_N-1:0] start_word;
    logic             busy;
    logic             done;
    logic             error;
    logic             overflow;
    logic [8:0]       code_count;
    logic [7:0]       rd_addr;
    logic [MAX_N-1:0] rd_data;

    modport master (
        output start, n, min_hd, start_word, rd_addr,
        input  busy, done, error, overflow, code_count, rd_data
    );

    modport slave (
        input  start, n, min_hd, start_word, rd_addr,
        output busy, done, error, overflow, code_count, rd_data
    );
endinterface

// File: rtl/icblbc_greedy_code_sequencer.sv
// Greedy fixed-length code builder: scans candidates 0..2^n-1 against accepted words.
// ICBLBC_EARLY_ABORT_EN: stop comparing a candidate at its first failing distance.
module icblbc_greedy_code_sequencer #(
    parameter int unsigned MAX_N    = 8,
    parameter int unsigned MAX_CODE = 256
) (
    input logic                           clock,
    input logic                           reset_n,
    icblbc_greedy_code_sequencer_if.slave bus
);
    localparam int unsigned CW   = MAX_N + 1;
    localparam int unsigned HW   = $clog2(MAX_N + 1);
    localparam int unsigned AW   = (MAX_CODE > 1) ? $clog2(MAX_CODE) : 1;
    localparam int unsigned CNTW = 9;
`ifdef ICBLBC_EARLY_ABORT_EN
    localparam bit EARLY_ABORT = 1'b1;
`else
    localparam bit EARLY_ABORT = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, CHECKP, ISSUE, CHECK, NEXT, DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        n_q, n_d, min_hd_q, min_hd_d;
    logic [MAX_N-1:0]  start_word_q, start_word_d;
    logic [CW-1:0]     cand_q, cand_d;
    logic [CNTW-1:0]   j_q, j_d, count_q, count_d;
    logic              rejected_q, rejected_d;
    logic [HW-1:0]     hd_q, hd_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              error_q, error_d, overflow_q, overflow_d;
    logic [CNTW-1:0]   code_count_q, code_count_d;
    logic [MAX_N-1:0]  rd_data_q, rd_data_d;

    logic [MAX_N-1:0]  code_mem_q [MAX_CODE];
    logic              mem_we_c;
    logic [AW-1:0]     mem_waddr_c;
    logic [MAX_N-1:0]  mem_wdata_c;
    logic [MAX_N-1:0]  op_a_c, op_b_c, diff_c;
    logic [CW-1:0]     max_word_c;
    logic [CNTW-1:0]   cnt_new_c;
    logic              rej_c;

    assign max_word_c = (CW'(1) << n_q) - CW'(1);

    // Hamming-distance unit: operands driven in ISSUE, result registered for CHECK
    always_comb begin
        diff_c = op_a_c ^ op_b_c;
        hd_d   = '0;
        for (int i = 0; i < MAX_N; i++) hd_d = hd_d + HW'(diff_c[i]);
    end

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        min_hd_d     = min_hd_q;
        start_word_d = start_word_q;
        cand_d       = cand_q;
        j_d          = j_q;
        count_d      = count_q;
        rejected_d   = rejected_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        error_d      = error_q;
        overflow_d   = overflow_q;
        code_count_d = code_count_q;
        mem_we_c     = 1'b0;
        mem_waddr_c  = '0;
        mem_wdata_c  = '0;
        op_a_c       = '0;
        op_b_c       = '0;
        cnt_new_c    = count_q;
        rej_c        = rejected_q;
        rd_data_d    = code_mem_q[AW'(bus.rd_addr)];

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    n_d          = bus.n;
                    min_hd_d     = bus.min_hd;
                    start_word_d = bus.start_word;
                    error_d      = 1'b0;
                    overflow_d   = 1'b0;
                    code_count_d = '0;
                    busy_d       = 1'b1;
                    state_d      = CHECKP;
                end
            end
            CHECKP: begin
                if ((n_q == 4'd0) || (32'(n_q) > MAX_N) || (min_hd_q == 4'd0) ||
                    (min_hd_q > n_q) || ({1'b0, start_word_q} > max_word_c)) begin
                    error_d = 1'b1;
                    count_d = '0;
                    state_d = DONE;
                end else begin
                    mem_we_c    = 1'b1;
                    mem_wdata_c = start_word_q;
                    count_d     = CNTW'(1);
                    cand_d      = '0;
                    j_d         = '0;
                    rejected_d  = 1'b0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                op_a_c  = MAX_N'(cand_q);
                op_b_c  = code_mem_q[AW'(j_q)];
                state_d = CHECK;
            end
            CHECK: begin
                rej_c      = rejected_q | (32'(hd_q) < 32'(min_hd_q));
                rejected_d = rej_c;
                if (!(EARLY_ABORT && rej_c) && ((j_q + CNTW'(1)) < count_q)) begin
                    j_d     = j_q + CNTW'(1);
                    state_d = ISSUE;
                end else begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (!rejected_q) begin
                    mem_we_c    = 1'b1;
                    mem_waddr_c = AW'(count_q);
                    mem_wdata_c = MAX_N'(cand_q);
                    cnt_new_c   = count_q + CNTW'(1);
                end
                count_d = cnt_new_c;
                if (cand_q == max_word_c) begin
                    state_d = DONE;
                end else if (cnt_new_c == CNTW'(MAX_CODE)) begin
                    overflow_d = 1'b1;
                    state_d    = DONE;
                end else begin
                    cand_d     = cand_q + CW'(1);
                    j_d        = '0;
                    rejected_d = 1'b0;
                    state_d    = ISSUE;
                end
            end
            DONE: begin
                done_d       = 1'b1;
                busy_d       = 1'b0;
                code_count_d = count_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            n_q          <= '0;
            min_hd_q     <= '0;
            start_word_q <= '0;
            cand_q       <= '0;
            j_q          <= '0;
            count_q      <= '0;
            rejected_q   <= 1'b0;
            hd_q         <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            overflow_q   <= 1'b0;
            code_count_q <= '0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            min_hd_q     <= min_hd_d;
            start_word_q <= start_word_d;
            cand_q       <= cand_d;
            j_q          <= j_d;
            count_q      <= count_d;
            rejected_q   <= rejected_d;
            hd_q         <= hd_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            overflow_q   <= overflow_d;
            code_count_q <= code_count_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // Code RAM has no reset; contents are meaningful only after a completed scan
    always_ff @(posedge clock) begin
        if (mem_we_c) code_mem_q[mem_waddr_c] <= mem_wdata_c;
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.overflow   = overflow_q;
    assign bus.code_count = code_count_q;
    assign bus.rd_data    = rd_data_q;
endmodule

// File: tb/tb_icblbc_greedy_code_sequencer.sv
// Self-checking bench for the greedy code sequencer: full-size and 4-word-RAM instances.
module tb_icblbc_greedy_code_sequencer;
    logic clock = 1'b0;
    logic reset_n;
    logic sel;
    always #5 clock = ~clock;

    icblbc_greedy_code_sequencer_if #(.MAX_N(8)) if_a ();
    icblbc_greedy_code_sequencer_if #(.MAX_N(8)) if_b ();

    icblbc_greedy_code_sequencer #(.MAX_N(8), .MAX_CODE(256)) dut_a (
        .clock(clock), .reset_n(reset_n), .bus(if_a));
    icblbc_greedy_code_sequencer #(.MAX_N(8), .MAX_CODE(4)) dut_b (
        .clock(clock), .reset_n(reset_n), .bus(if_b));

    logic       busy_m, done_m, error_m, overflow_m;
    logic [8:0] count_m;
    logic [7:0] rd_data_m;
    assign busy_m     = sel ? if_b.busy       : if_a.busy;
    assign done_m     = sel ? if_b.done       : if_a.done;
    assign error_m    = sel ? if_b.error      : if_a.error;
    assign overflow_m = sel ? if_b.overflow   : if_a.overflow;
    assign count_m    = sel ? if_b.code_count : if_a.code_count;
    assign rd_data_m  = sel ? if_b.rd_data    : if_a.rd_data;

    typedef struct {
        bit               b;
        int               n, hd, sw;
        bit               err, ovf;
        int               cnt;
        logic [7:0][7:0]  code;
    } vec_t;

    typedef struct {
        bit               err, ovf;
        int               cnt, busy;
        logic [7:0][7:0]  code;
    } exp_t;

    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t sb[$];
    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0][7:0] cw(input int c0, c1, c2, c3, c4, c5, c6, c7);
        logic [7:0][7:0] r;
        r[0] = 8'(c0); r[1] = 8'(c1); r[2] = 8'(c2); r[3] = 8'(c3);
        r[4] = 8'(c4); r[5] = 8'(c5); r[6] = 8'(c6); r[7] = 8'(c7);
        return r;
    endfunction

    // Busy length from the cycle-count formula, given greedy acceptance
    function automatic int model_busy(input int n, hd, sw, maxc);
        int code[256];
        int cnt, busy, k;
        bit rej, early;
`ifdef ICBLBC_EARLY_ABORT_EN
        early = 1'b1;
`else
        early = 1'b0;
`endif
        if (n == 0 || n > 8 || hd == 0 || hd > n || sw >= (1 << n)) return 2;
        code[0] = sw;
        cnt = 1;
        busy = 2;
        for (int c = 0; c < (1 << n); c++) begin
            rej = 1'b0;
            k = 0;
            for (int j = 0; j < cnt; j++) begin
                k++;
                if ($countones(c ^ code[j]) < hd) rej = 1'b1;
                if (early && rej) break;
            end
            busy += 2 * k + 1;
            if (!rej) begin
                code[cnt] = c;
                cnt++;
            end
            if (c == (1 << n) - 1) break;
            if (cnt == maxc) break;
        end
        return busy;
    endfunction

    task automatic drive(input bit st, input int n, hd, sw);
        if (sel) begin
            if_b.start = st; if_b.n = 4'(n); if_b.min_hd = 4'(hd); if_b.start_word = 8'(sw);
        end else begin
            if_a.start = st; if_a.n = 4'(n); if_a.min_hd = 4'(hd); if_a.start_word = 8'(sw);
        end
    endtask

    task automatic set_addr(input int a);
        if (sel) if_b.rd_addr = 8'(a);
        else     if_a.rd_addr = 8'(a);
    endtask

    task automatic run(input vec_t v, input bit poke, input string tag);
        exp_t e;
        int   cycles;
        bit   seen;
        sel    = v.b;
        e.err  = v.err;
        e.ovf  = v.ovf;
        e.cnt  = v.cnt;
        e.code = v.code;
        e.busy = model_busy(v.n, v.hd, v.sw, v.b ? 4 : 256);
        sb.push_back(e);
        @(negedge clock);
        drive(1'b1, v.n, v.hd, v.sw);
        @(negedge clock);
        drive(1'b0, v.n, v.hd, v.sw);
        cycles = 0;
        seen   = 1'b0;
        for (int t = 0; t < 5000 && !seen; t++) begin
            if (done_m) begin
                seen = 1'b1;
            end else begin
                if (busy_m) cycles++;
                if (poke && cycles == 5) drive(1'b1, 9, 0, 255);
                else                     drive(1'b0, v.n, v.hd, v.sw);
                @(negedge clock);
            end
        end
        drive(1'b0, v.n, v.hd, v.sw);
        e = sb.pop_front();
        chk({tag, " done_seen"}, 32'(seen), 32'd1);
        chk({tag, " busy_at_done"}, 32'(busy_m), 32'd0);
        chk({tag, " error"}, 32'(error_m), 32'(e.err));
        chk({tag, " overflow"}, 32'(overflow_m), 32'(e.ovf));
        chk({tag, " code_count"}, 32'(count_m), 32'(e.cnt));
        chk({tag, " busy_cycles"}, 32'(cycles), 32'(e.busy));
        for (int i = 0; i < e.cnt && i < 8; i++) begin
            set_addr(i);
            @(negedge clock);
            if (i == 0) chk({tag, " done_one_cycle"}, 32'(done_m), 32'd0);
            chk($sformatf("%s code[%0d]", tag, i), 32'(rd_data_m), 32'(e.code[i]));
        end
        @(negedge clock);
        chk({tag, " flags_held"}, 32'({error_m, overflow_m, count_m}),
            32'({e.err, e.ovf, 9'(e.cnt)}));
    endtask

    initial begin
        sel = 1'b0;
        if_a.start = 1'b0; if_a.n = '0; if_a.min_hd = '0; if_a.start_word = '0; if_a.rd_addr = '0;
        if_b.start = 1'b0; if_b.n = '0; if_b.min_hd = '0; if_b.start_word = '0; if_b.rd_addr = '0;

        //          b  n  hd  sw  err ovf cnt code
        vecs[0]  = '{0, 3, 3, 0,  0, 0, 2, cw(0, 7, 0, 0, 0, 0, 0, 0)};
        vecs[1]  = '{0, 4, 2, 0,  0, 0, 8, cw(0, 3, 5, 6, 9, 10, 12, 15)};
        vecs[2]  = '{0, 3, 1, 5,  0, 0, 8, cw(5, 0, 1, 2, 3, 4, 6, 7)};
        vecs[3]  = '{0, 9, 1, 0,  1, 0, 0, cw(0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[4]  = '{0, 4, 0, 0,  1, 0, 0, cw(0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[5]  = '{0, 4, 1, 16, 1, 0, 0, cw(0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[6]  = '{0, 3, 4, 0,  1, 0, 0, cw(0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[7]  = '{0, 0, 1, 0,  1, 0, 0, cw(0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[8]  = '{0, 8, 8, 0,  0, 0, 2, cw(0, 255, 0, 0, 0, 0, 0, 0)};
        vecs[9]  = '{0, 1, 1, 1,  0, 0, 2, cw(1, 0, 0, 0, 0, 0, 0, 0)};
        vecs[10] = '{1, 4, 1, 0,  0, 1, 4, cw(0, 1, 2, 3, 0, 0, 0, 0)};

        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset a", 32'({if_a.busy, if_a.done, if_a.error, if_a.overflow, if_a.code_count, if_a.rd_data}), 32'd0);
        chk("reset b", 32'({if_b.busy, if_b.done, if_b.error, if_b.overflow, if_b.code_count, if_b.rd_data}), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++) run(vecs[i], 1'b0, $sformatf("vec%0d", i));

        // Reset in the middle of a scan aborts without a done pulse
        begin
            bit saw_done;
            sel = 1'b0;
            @(negedge clock);
            drive(1'b1, 4, 2, 0);
            @(negedge clock);
            drive(1'b0, 4, 2, 0);
            repeat (20) @(negedge clock);
            chk("midscan busy", 32'(busy_m), 32'd1);
            reset_n = 1'b0;
            @(negedge clock);
            reset_n = 1'b1;
            chk("abort busy", 32'(busy_m), 32'd0);
            saw_done = 1'b0;
            for (int t = 0; t < 400; t++) begin
                if (done_m) saw_done = 1'b1;
                @(negedge clock);
            end
            chk("abort no_done", 32'(saw_done), 32'd0);
        end

        // Restart with a stray start (illegal params) pulsed while busy
        run(vecs[0], 1'b1, "restart");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/icblbc_greedy_code_sequencer.md
Name: icblbc_greedy_code_sequencer

Overview:
- Controller that builds a greedy fixed-length code by scanning every candidate word 0..2^n-1 in ascending order.
- Owns one registered Hamming-distance unit and schedules it: each candidate is compared against every codeword accepted so far.
- A candidate is accepted when every distance is >= min_hd.
- Sits beside the isolation-search logic; the accepted code is read back through a registered read port.

Parameters:
- MAX_N, 8, maximum word width in bits; words are MAX_N bits wide.
- MAX_CODE, 256, capacity of the accepted-code RAM in words.

Ports:
- clock  in  1  single system clock; all logic on posedge.
- reset_n  in  1  reset; one clock, synchronous, active-low.
- start  in  1  request to begin a scan; sampled only in IDLE.
- n  in  4  active word width, legal range 1..MAX_N.
- min_hd  in  4  required minimum pairwise distance, legal range 1..MAX_N.
- start_word  in  MAX_N  seed codeword, must be < 2^n.
- busy  out  1  high from the cycle after start is accepted until the cycle done pulses.
- done  out  1  one-cycle completion pulse.
- error  out  1  parameters illegal; valid with done, held until next accepted start.
- overflow  out  1  code RAM filled before the scan ended; valid with done, held until next start.
- code_count  out  9  number of accepted words; valid with done, held until next start.
- rd_addr  in  8  read address into the code RAM.
- rd_data  out  MAX_N  code[rd_addr], registered, 1-cycle latency.

Behaviour:
- Reset (reset_n=0 at posedge): state=IDLE; busy, done, error, overflow = 0; code_count=0; rd_data=0; RAM contents undefined.
- Reset mid-scan aborts immediately: no done pulse, state returns to IDLE.
- Distance unit: popcount(a^b) registered. Result is valid the cycle after the operands are driven.
- States and transitions:
  - IDLE: on start=1, latch n, min_hd and start_word, clear flags, go to CHECKP. start while busy is ignored.
  - CHECKP (1 cycle): if n==0, n>MAX_N, min_hd==0, min_hd>n, or start_word>=2^n, then set error and go to DONE with code_count=0. Otherwise write code[0]=start_word, count=1, cand=0, j=0, go to ISSUE.
  - ISSUE (1 cycle): drive operands cand and code[j]; go to CHECK.
  - CHECK (1 cycle): if distance < min_hd, mark candidate rejected. If j+1 < count (and not aborted, see Optional Feature), set j=j+1 and go to ISSUE; else go to NEXT.
  - NEXT (1 cycle): if not rejected, write code[count]=cand and count=count+1. If the new count==MAX_CODE and cand<2^n-1, set overflow and go to DONE. If cand==2^n-1, go to DONE. Else set cand=cand+1, j=0, clear rejected, go to ISSUE.
  - DONE (1 cycle): done=1, busy=0, code_count=count; go to IDLE.
- Candidates equal to an accepted word have distance 0 and are rejected naturally; no special skip.
- Candidate counter is 9 bits, so 2^8-1 terminates without wrap.
- code_count width holds MAX_CODE=256.
- Busy duration for a legal run = 2 + sum over candidates of (2*k_c + 1), where k_c = comparisons issued for that candidate.
- rd_data is registered every cycle regardless of state. Contents are stable only while busy=0.

Optional Feature:
- Macro ICBLBC_EARLY_ABORT_EN.
- Defined: CHECK goes straight to NEXT on the first failing distance, so k_c is at most the index of the first failing word + 1.
- Undefined: every candidate is compared against all count words.
- Accepted code, code_count, overflow and error are identical in both builds; only busy duration differs.

Test Plan:
- n=3, min_hd=3, start_word=0 -> code_count=2, code={0,7}; busy high 26 cycles in either build.
- n=4, min_hd=2, start_word=0 -> code_count=8, code={0,3,5,6,9,10,12,15}, overflow=0. Busy is 2+(2+...) per formula; the early-abort build is strictly shorter.
- n=3, min_hd=1, start_word=5 -> code_count=8, code={5,0,1,2,3,4,6,7}.
- MAX_CODE=4, n=4, min_hd=1, start_word=0 -> overflow=1, code_count=4, code={0,1,2,3}; done arrives after cand=3.
- Error cases, each -> done pulses 2 cycles after start with error=1, code_count=0: n=9; then min_hd=0; then start_word=16 with n=4.
- Reset and restart: assert reset_n=0 mid-scan -> busy=0, done never pulses. A restart with n=3, min_hd=3, start_word=0 gives code_count=2. start pulsed while busy is ignored.
